// File: rtl/mixcolumn_fwd_seq_if.sv
// Handshake bundle for the forward MixColumns engine: an input state channel,
// an output result channel and a busy indicator.
interface mixcolumn_fwd_seq_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         in_last;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         busy;

   // Producer/consumer side (round controller)
   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, busy
   );

   // Engine side
   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/mixcolumn_fwd_seq.sv
// Sequential forward AES MixColumns. A captured state is transformed
// COLS_PER_CYCLE columns per clock and then held until the consumer takes it.
// in_last bypasses the transform with identical latency (final AES round).
module mixcolumn_fwd_seq #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   mixcolumn_fwd_seq_if.slave bus
);

   generate
      if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
         $error("mixcolumn_fwd_seq: COLS_PER_CYCLE must be 1, 2 or 4");
      end
   endgenerate

   // Column counter value of the final BUSY cycle, and its per-cycle step.
   // With four columns per cycle the first BUSY cycle is also the last.
   localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);
   localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE % 4);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]   state_q, state_d;
   logic [127:0] src_q, src_d;
   logic [127:0] dst_q, dst_d;
   logic         byp_q, byp_d;
   logic [1:0]   col_cnt_q, col_cnt_d;

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
   endfunction

   // One column: row 0 is the most significant byte
   function automatic logic [31:0] mix_column(input logic [31:0] c);
      logic [7:0] s0, s1, s2, s3;
      logic [7:0] r0, r1, r2, r3;
      s0 = c[31:24];
      s1 = c[23:16];
      s2 = c[15:8];
      s3 = c[7:0];
      r0 = xtime(s0) ^ (xtime(s1) ^ s1) ^ s2 ^ s3;
      r1 = s0 ^ xtime(s1) ^ (xtime(s2) ^ s2) ^ s3;
      r2 = s0 ^ s1 ^ xtime(s2) ^ (xtime(s3) ^ s3);
      r3 = (xtime(s0) ^ s0) ^ s1 ^ s2 ^ xtime(s3);
      return {r0, r1, r2, r3};
   endfunction

   // Next-state logic: capture in IDLE, fill dst columns in BUSY, hold in DONE
   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      byp_d     = byp_q;
      dst_d     = dst_q;
      col_cnt_d = col_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               src_d     = bus.in_data;
               byp_d     = bus.in_last;
               col_cnt_d = 2'd0;
               state_d   = ST_BUSY;
            end
         end
         ST_BUSY: begin
            for (int j = 0; j < COLS_PER_CYCLE; j++) begin
               dst_d[127 - 32*(int'(col_cnt_q) + j) -: 32] = byp_q
                  ? src_q[127 - 32*(int'(col_cnt_q) + j) -: 32]
                  : mix_column(src_q[127 - 32*(int'(col_cnt_q) + j) -: 32]);
            end
            if (col_cnt_q == LAST_CNT) begin
               col_cnt_d = 2'd0;
               state_d   = ST_DONE;
            end else begin
               col_cnt_d = col_cnt_q + STEP;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any partial state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         src_q     <= 128'h0;
         dst_q     <= 128'h0;
         byp_q     <= 1'b0;
         col_cnt_q <= 2'd0;
      end else begin
         state_q   <= state_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         byp_q     <= byp_d;
         col_cnt_q <= col_cnt_d;
      end
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.out_data  = dst_q;

endmodule

// File: tb/tb_mixcolumn_fwd_seq.sv
// Directed bench for mixcolumn_fwd_seq: three instances (1, 2 and 4 columns
// per cycle) share clock and reset; each scenario task drives one instance.
module tb_mixcolumn_fwd_seq;

   logic clk;
   logic rst_n;

   logic         iv   [3];
   logic         il   [3];
   logic         ordy [3];
   logic [127:0] id   [3];
   logic         ov   [3];
   logic         ir   [3];
   logic         bsy  [3];
   logic [127:0] od   [3];

   int n_checks;
   int n_fail;

   localparam logic [127:0] V1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
   localparam logic [127:0] V1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
   localparam logic [127:0] V2_IN  = 128'hd4d4d4d5_2d26314c_db135345_f20a225c;
   localparam logic [127:0] V2_OUT = 128'hd5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d;
   localparam logic [127:0] VB     = 128'h00112233_44556677_8899aabb_ccddeeff;

   mixcolumn_fwd_seq_if bus0 ();
   mixcolumn_fwd_seq_if bus1 ();
   mixcolumn_fwd_seq_if bus2 ();

   mixcolumn_fwd_seq #(.COLS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
   mixcolumn_fwd_seq #(.COLS_PER_CYCLE(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
   mixcolumn_fwd_seq #(.COLS_PER_CYCLE(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

   assign bus0.in_valid = iv[0];  assign bus0.in_data = id[0];
   assign bus0.in_last = il[0];   assign bus0.out_ready = ordy[0];
   assign bus1.in_valid = iv[1];  assign bus1.in_data = id[1];
   assign bus1.in_last = il[1];   assign bus1.out_ready = ordy[1];
   assign bus2.in_valid = iv[2];  assign bus2.in_data = id[2];
   assign bus2.in_last = il[2];   assign bus2.out_ready = ordy[2];

   assign ov[0] = bus0.out_valid; assign ir[0] = bus0.in_ready;
   assign bsy[0] = bus0.busy;     assign od[0] = bus0.out_data;
   assign ov[1] = bus1.out_valid; assign ir[1] = bus1.in_ready;
   assign bsy[1] = bus1.busy;     assign od[1] = bus1.out_data;
   assign ov[2] = bus2.out_valid; assign ir[2] = bus2.in_ready;
   assign bsy[2] = bus2.busy;     assign od[2] = bus2.out_data;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int ncyc(input int k);
      return (k == 0) ? 4 : (k == 1) ? 2 : 1;
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
      end
      return p;
   endfunction

   // Inverse MixColumns reference used to close the round trip
   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0] a0, a1, a2, a3;
      r = 128'h0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127 - 32*c -: 8];
         a1 = s[119 - 32*c -: 8];
         a2 = s[111 - 32*c -: 8];
         a3 = s[103 - 32*c -: 8];
         r[127 - 32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
         r[119 - 32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
         r[111 - 32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
         r[103 - 32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One transfer on instance k; returns result and cycles from acceptance to out_valid
   task automatic xfer(input int k, input logic [127:0] d, input logic last,
                       output logic [127:0] got, output int lat);
      int guard;
      guard = 0;
      while (!ir[k] && guard < 50) begin
         step();
         guard++;
      end
      iv[k] = 1'b1;
      id[k] = d;
      il[k] = last;
      step();
      iv[k] = 1'b0;
      lat = 0;
      while (!ov[k] && lat < 50) begin
         step();
         lat++;
      end
      got = od[k];
      n_checks++;
      if (ov[k] !== 1'b1) begin
         n_fail++;
         $display("FAIL xfer_timeout dut%0d: out_valid=%b required 1", k, ov[k]);
      end
      ordy[k] = 1'b1;
      step();
      ordy[k] = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      step();
      step();
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (ir[k] !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready dut%0d: got %b required 1", k, ir[k]); end
         n_checks++;
         if (ov[k] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid dut%0d: got %b required 0", k, ov[k]); end
         n_checks++;
         if (bsy[k] !== 1'b0) begin n_fail++; $display("FAIL reset_busy dut%0d: got %b required 0", k, bsy[k]); end
         n_checks++;
         if (od[k] !== 128'h0) begin n_fail++; $display("FAIL reset_out_data dut%0d: got %h required 0", k, od[k]); end
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_known_vector();
      logic [127:0] got;
      logic [127:0] vin;
      logic [127:0] vexp;
      int lat;
      for (int k = 0; k < 3; k++) begin
         vin  = (k == 0) ? V1_IN  : V2_IN;
         vexp = (k == 0) ? V1_OUT : V2_OUT;
         xfer(k, vin, 1'b0, got, lat);
         n_checks++;
         if (got !== vexp) begin n_fail++; $display("FAIL known_data dut%0d: got %h required %h", k, got, vexp); end
         n_checks++;
         if (lat != ncyc(k)) begin n_fail++; $display("FAIL known_latency dut%0d: got %0d required %0d", k, lat, ncyc(k)); end
         n_checks++;
         if (ir[k] !== 1'b1 || ov[k] !== 1'b0) begin
            n_fail++; $display("FAIL known_after_hs dut%0d: in_ready=%b out_valid=%b required 1/0", k, ir[k], ov[k]);
         end
      end
      // The second vector on the one-column instance too
      xfer(0, V2_IN, 1'b0, got, lat);
      n_checks++;
      if (got !== V2_OUT) begin n_fail++; $display("FAIL known_v2_dut0: got %h required %h", got, V2_OUT); end
   endtask

   task automatic test_bypass();
      logic [127:0] got;
      int lat;
      for (int k = 0; k < 3; k++) begin
         xfer(k, VB, 1'b1, got, lat);
         n_checks++;
         if (got !== VB) begin n_fail++; $display("FAIL bypass_data dut%0d: got %h required %h", k, got, VB); end
         n_checks++;
         if (lat != ncyc(k)) begin n_fail++; $display("FAIL bypass_latency dut%0d: got %0d required %0d", k, lat, ncyc(k)); end
      end
   endtask

   task automatic test_backpressure();
      int lat;
      iv[0] = 1'b1;
      id[0] = V1_IN;
      il[0] = 1'b0;
      step();
      iv[0] = 1'b0;
      lat = 0;
      while (!ov[0] && lat < 50) begin step(); lat++; end
      for (int c = 0; c < 10; c++) begin
         n_checks++;
         if (ov[0] !== 1'b1 || od[0] !== V1_OUT || ir[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_hold cyc%0d: out_valid=%b in_ready=%b data=%h required 1/0/%h",
                     c, ov[0], ir[0], od[0], V1_OUT);
         end
         iv[0] = (c == 3);
         id[0] = (c == 3) ? V2_IN : V1_IN;
         step();
      end
      iv[0] = 1'b0;
      ordy[0] = 1'b1;
      step();
      ordy[0] = 1'b0;
      n_checks++;
      if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin
         n_fail++; $display("FAIL backpressure_release: in_ready=%b out_valid=%b required 1/0", ir[0], ov[0]);
      end
      for (int c = 0; c < 6; c++) begin
         step();
         n_checks++;
         if (ov[0] !== 1'b0 || bsy[0] !== 1'b0) begin
            n_fail++; $display("FAIL backpressure_ignored cyc%0d: out_valid=%b busy=%b required 0/0", c, ov[0], bsy[0]);
         end
      end
   endtask

   task automatic test_reset_mid_busy();
      logic [127:0] got;
      int lat;
      iv[0] = 1'b1;
      id[0] = V2_IN;
      il[0] = 1'b0;
      step();
      iv[0] = 1'b0;
      step();
      step();
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || bsy[0] !== 1'b0 || od[0] !== 128'h0) begin
         n_fail++;
         $display("FAIL midbusy_async: in_ready=%b out_valid=%b busy=%b data=%h required 1/0/0/0",
                  ir[0], ov[0], bsy[0], od[0]);
      end
      step();
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         step();
         n_checks++;
         if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL midbusy_no_output cyc%0d: out_valid=%b required 0", c, ov[0]); end
      end
      xfer(0, V1_IN, 1'b0, got, lat);
      n_checks++;
      if (got !== V1_OUT) begin n_fail++; $display("FAIL midbusy_recover: got %h required %h", got, V1_OUT); end
   endtask

   task automatic test_round_trip();
      logic [127:0] d;
      logic [127:0] got;
      int lat;
      int bad;
      for (int k = 0; k < 3; k++) begin
         bad = 0;
         for (int t = 0; t < 1000; t++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            xfer(k, d, 1'b0, got, lat);
            n_checks++;
            if (inv_mix(got) !== d) begin
               n_fail++;
               bad++;
               if (bad < 5) $display("FAIL round_trip dut%0d: inv(out)=%h required %h", k, inv_mix(got), d);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int prev;
      int hits;
      int len;
      for (int k = 0; k < 3; k++) begin
         iv[k] = 1'b1;
         id[k] = V2_IN;
         il[k] = 1'b0;
         ordy[k] = 1'b1;
         prev = -1;
         hits = 0;
         len = 6 * (ncyc(k) + 2);
         for (int c = 1; c <= len; c++) begin
            step();
            if (ov[k]) begin
               n_checks++;
               if (od[k] !== V2_OUT) begin n_fail++; $display("FAIL b2b_data dut%0d: got %h required %h", k, od[k], V2_OUT); end
               if (prev >= 0) begin
                  n_checks++;
                  if (c - prev != ncyc(k) + 2) begin
                     n_fail++; $display("FAIL b2b_interval dut%0d: got %0d required %0d", k, c - prev, ncyc(k) + 2);
                  end
               end
               prev = c;
               hits++;
            end
         end
         iv[k] = 1'b0;
         for (int c = 0; c < 8; c++) step();
         ordy[k] = 1'b0;
         n_checks++;
         if (hits != 6) begin n_fail++; $display("FAIL b2b_count dut%0d: got %0d required 6", k, hits); end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      for (int k = 0; k < 3; k++) begin
         iv[k] = 1'b0;
         il[k] = 1'b0;
         ordy[k] = 1'b0;
         id[k] = 128'h0;
      end
      test_reset();
      test_known_vector();
      test_bypass();
      test_backpressure();
      test_reset_mid_busy();
      test_round_trip();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mixcolumn_fwd_seq.md
Name: mixcolumn_fwd_seq

Overview:
- Forward AES MixColumns engine for the encrypt datapath; counterpart of the combinational inverse MixColumns used on the decrypt side.
- Accepts a 128-bit state over a valid/ready handshake and processes COLS_PER_CYCLE columns per clock.
- Presents the result in a held output register with its own valid/ready handshake.
- An in_last flag bypasses the transform for the final AES round, which has no MixColumns, so the round controller sees uniform latency.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per BUSY cycle; legal values 1, 2, 4. Any other value is a compile-time error. N = 4/COLS_PER_CYCLE.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input state valid
- in_ready  out  1  engine can accept a state
- in_data  in  128  state; column c occupies bits [127-32c -: 32], row 0 in the MS byte
- in_last  in  1  final round: pass in_data through unchanged
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  128  transformed state, same byte layout
- busy  out  1  high in BUSY or DONE

Behaviour:
- Column transform (GF(2^8), polynomial 0x11B; xtime(x) = (x<<1) ^ (x[7] ? 8'h1B : 0)):
  - r0 = 2s0^3s1^s2^s3
  - r1 = s0^2s1^3s2^s3
  - r2 = s0^s1^2s2^3s3
  - r3 = 3s0^s1^s2^2s3
  - 3x = xtime(x)^x. No carries leave 8 bits.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, capture in_data into src_reg and in_last into byp_reg, clear col_cnt, go to BUSY.
  - BUSY: each cycle writes columns col_cnt..col_cnt+COLS_PER_CYCLE-1 of dst_reg. Each column gets either its transform or, when byp_reg=1, the source column unchanged. col_cnt advances by COLS_PER_CYCLE. After the Nth BUSY cycle, go to DONE.
  - DONE: out_valid=1; out_data=dst_reg is stable. On out_ready, go to IDLE.
- Latency: the acceptance edge is E0. out_valid rises after edge E_N and stays high until the edge where out_ready=1 is sampled. In the cycle after that edge in_ready=1 again, giving throughput of one state per N+2 cycles.
- in_ready = (state==IDLE), combinational from state only. in_valid in BUSY or DONE is ignored and in_data is not sampled.
- out_valid is deasserted only on handshake. out_data never changes while out_valid=1. out_data outside DONE holds the last result and is don't-care to consumers.
- col_cnt is 2 bits and wraps 3→0 only via the transition to DONE, never mid-state.
- busy = (state != IDLE).
- Reset (rst_n low, at any time including mid-BUSY or DONE):
  - State goes to IDLE immediately.
  - in_ready=1, out_valid=0, busy=0.
  - out_data, dst_reg, src_reg = 128'h0; col_cnt=0; byp_reg=0.
  - A partially processed state is discarded with no output.
- Deassertion of reset is synchronised externally. The first acceptance can occur at the first rising edge with rst_n high.

Test Plan:
- Known vector, COLS_PER_CYCLE=1: in_data=db135345_f20a225c_01010101_c6c6c6c6, in_last=0 → out_data=8e4da1bc_9fdc589d_01010101_c6c6c6c6. out_valid rises 4 cycles after acceptance.
- Second vector with COLS_PER_CYCLE=2 and 4: in_data=d4d4d4d5_2d26314c_db135345_f20a225c → d5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d. Latency is 2 and 1 cycles respectively.
- Bypass: in_last=1, in_data=00112233_44556677_8899aabb_ccddeeff → identical out_data with the same latency as non-bypass.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → out_valid and out_data stable, in_ready=0. A new in_valid pulse during this window is not accepted. Releasing out_ready gives a handshake, and in_ready is 1 the next cycle.
- Reset mid-BUSY: assert rst_n=0 two cycles after acceptance → outputs drop to reset values asynchronously, and out_valid never pulses for that state. A vector sent after reset produces a correct result.
- Round-trip: 1000 random states through this block, then through the team's inverse MixColumns → the original state is recovered each time. Back-to-back in_valid with out_ready=1 gives exactly one transfer per N+2 cycles.
